// File: rtl/signextend_pkg.sv
// Shared opcode constants and immediate-format encoding for the ID-stage
// immediate generator (signextend, signextend_decode).
package signextend_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ANDI  = 4'b0110;
  localparam logic [3:0] OP_ORI   = 4'b0111;
  localparam logic [3:0] OP_LW    = 4'b1000;
  localparam logic [3:0] OP_SW    = 4'b1011;
  localparam logic [3:0] OP_BEQ   = 4'b1100;
  localparam logic [3:0] OP_BNE   = 4'b1101;
  localparam logic [3:0] OP_JMP   = 4'b1111;

  // Immediate width and extension kind carried by each instruction format.
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_S4   = 3'd1,
    FMT_S8   = 3'd2,
    FMT_Z8   = 3'd3,
    FMT_S12  = 3'd4
  } fmt_e;

  function automatic logic fmt_has_imm(input fmt_e fmt);
    return (fmt != FMT_NONE);
  endfunction

endpackage

// File: rtl/signextend_decode.sv
// Combinational opcode-to-immediate-format decoder.
// SIGNEXTEND_ZERO_EXT_EN selects zero extension for ANDI/ORI.
module signextend_decode
  import signextend_pkg::*;
(
  input  logic [3:0] i_opcode,
  output fmt_e       o_fmt
);

  always_comb begin
    o_fmt = FMT_NONE;
    case (i_opcode)
      OP_ADDI:          o_fmt = FMT_S8;
`ifdef SIGNEXTEND_ZERO_EXT_EN
      OP_ANDI, OP_ORI:  o_fmt = FMT_Z8;
`else
      OP_ANDI, OP_ORI:  o_fmt = FMT_S8;
`endif
      OP_LW, OP_SW:     o_fmt = FMT_S4;
      OP_BEQ, OP_BNE:   o_fmt = FMT_S8;
      OP_JMP:           o_fmt = FMT_S12;
      default:          o_fmt = FMT_NONE;
    endcase
  end

endmodule

// File: rtl/signextend.sv
// ID-stage immediate generator: field select, sign/zero extend, one register
// stage with stall enable. SIGNEXTEND_ZERO_EXT_EN zero-extends ANDI/ORI.
module signextend
  import signextend_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  opcode,
  input  logic [3:0]  one,
  input  logic [3:0]  two,
  input  logic [3:0]  three,
  output logic [15:0] extendOutput,
  output logic        imm_valid
);

  fmt_e        w_fmt;
  logic [15:0] w_ext;
  logic [15:0] r_ext;
  logic        r_imm_valid;

  signextend_decode u_decode (
    .i_opcode (opcode),
    .o_fmt    (w_fmt)
  );

  always_comb begin
    w_ext = 16'h0000;
    case (w_fmt)
      FMT_S4:  w_ext = {{12{three[3]}}, three};
      FMT_S8:  w_ext = {{8{two[3]}}, two, three};
      FMT_Z8:  w_ext = {8'h00, two, three};
      FMT_S12: w_ext = {{4{one[3]}}, one, two, three};
      default: w_ext = 16'h0000;
    endcase
  end

  // en is the only flow control: high captures this cycle's instruction,
  // low stalls and holds the last captured immediate. Reset overrides en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ext       <= 16'h0000;
      r_imm_valid <= 1'b0;
    end else if (en) begin
      r_ext       <= w_ext;
      r_imm_valid <= fmt_has_imm(w_fmt);
    end
  end

  assign extendOutput = r_ext;
  assign imm_valid    = r_imm_valid;

endmodule

// File: tb/tb_signextend.sv
// Scoreboard bench for signextend: driver predicts from an arithmetic model,
// monitor compares one cycle later. Honours SIGNEXTEND_ZERO_EXT_EN.
module tb_signextend;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  opcode;
  logic [3:0]  one;
  logic [3:0]  two;
  logic [3:0]  three;
  logic [15:0] extendOutput;
  logic        imm_valid;

  logic [16:0] exp_q[$];
  logic [16:0] m_state;
  int          n_tests = 0;
  int          n_fail  = 0;

  signextend dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .opcode       (opcode),
    .one          (one),
    .two          (two),
    .three        (three),
    .extendOutput (extendOutput),
    .imm_valid    (imm_valid)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Value of the immediate as a signed/unsigned integer, then 16-bit two's complement.
  function automatic logic [16:0] model(input logic [3:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
    int   v;
    logic has;
    logic [15:0] r;
    v   = 0;
    has = 1'b1;
    case (op)
      4'b0101, 4'b1100, 4'b1101: begin
        v = b * 16 + c;
        if (v >= 128) v = v - 256;
      end
      4'b0110, 4'b0111: begin
        v = b * 16 + c;
`ifndef SIGNEXTEND_ZERO_EXT_EN
        if (v >= 128) v = v - 256;
`endif
      end
      4'b1000, 4'b1011: begin
        v = c;
        if (v >= 8) v = v - 16;
      end
      4'b1111: begin
        v = a * 256 + b * 16 + c;
        if (v >= 2048) v = v - 4096;
      end
      default: begin
        v   = 0;
        has = 1'b0;
      end
    endcase
    r = 16'(v);
    return {has, r};
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic e);
    @(negedge clk);
    opcode = op;
    one    = a;
    two    = b;
    three  = c;
    en     = e;
    if (e) m_state = model(op, a, b, c);
    exp_q.push_back(m_state);
  endtask

  // Async reset asserted mid-cycle with en high; outputs must clear before any edge.
  task automatic reset_test();
    @(posedge clk);
    #3;
    en  = 1'b1;
    rst = 1'b1;
    #1;
    check16("reset_async_ext", extendOutput, 16'h0000);
    check16("reset_async_valid", {15'd0, imm_valid}, 16'h0000);
    m_state = 17'd0;
    @(negedge clk);
    check16("reset_hold_ext", extendOutput, 16'h0000);
    rst = 1'b0;
    en  = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always begin
    logic [16:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check16("ext", extendOutput, e[15:0]);
      check16("valid", {15'd0, imm_valid}, {15'd0, e[16]});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b0;
    opcode = 4'h0; one = 4'h0; two = 4'h0; three = 4'h0;
    m_state = 17'd0;
    #1;
    check16("reset_init_ext", extendOutput, 16'h0000);
    check16("reset_init_valid", {15'd0, imm_valid}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    drive(4'b1000, 4'h1, 4'h2, 4'h3, 1'b1);  // LW  -> 0003
    drive(4'b1000, 4'h1, 4'h2, 4'hC, 1'b1);  // LW  -> FFFC
    drive(4'b0101, 4'h1, 4'h2, 4'h3, 1'b1);  // ADDI -> 0023
    drive(4'b1100, 4'h1, 4'h2, 4'h3, 1'b1);  // BEQ -> 0023
    drive(4'b1100, 4'h1, 4'h8, 4'h0, 1'b1);  // BEQ -> FF80
    drive(4'b1111, 4'h8, 4'h2, 4'h3, 1'b1);  // JMP -> F823
    drive(4'b0000, 4'h1, 4'h2, 4'h3, 1'b1);  // R-type -> 0000, invalid
    drive(4'b0101, 4'h1, 4'h2, 4'h3, 1'b1);  // capture 0023
    repeat (3) drive(4'b1111, 4'h8, 4'h2, 4'h3, 1'b0);  // stalled, hold 0023
    drive(4'b1111, 4'h8, 4'h2, 4'h3, 1'b1);  // F823
    drive(4'b0110, 4'h1, 4'h8, 4'h0, 1'b1);  // ANDI: 0080 or FF80 per build
    drive(4'b0111, 4'h0, 4'h7, 4'hF, 1'b1);  // ORI positive
    drive(4'b1011, 4'h0, 4'h0, 4'h8, 1'b1);  // SW -> FFF8
    drive(4'b1101, 4'h0, 4'h7, 4'hF, 1'b1);  // BNE -> 007F

    reset_test();
    drive(4'b1111, 4'hF, 4'hF, 4'hF, 1'b0);  // still zero after reset while stalled
    drive(4'b1111, 4'h7, 4'hF, 4'hF, 1'b1);  // 07FF

    for (int i = 0; i < 300; i++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0));
      if (i == 150) reset_test();
    end

    repeat (3) @(posedge clk);
    #2;
    check16("queue_drain", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
